// File: rtl/demapper_serializer_if.sv
// Bundle between demapper_serializer and its neighbours: the parallel frame
// input with its handshake, and the serial sample output with its handshake.
interface demapper_serializer_if #(
  parameter int data_width = 8,
  parameter int no_in_out  = 32
);
  localparam int idx_w = $clog2(no_in_out);

  // valid/ready: a transfer happens on each rising edge where both are high;
  // ready may depend combinationally on the other side's valid/ready.
  logic                            in_valid;
  logic                            in_ready;
  logic [no_in_out*data_width-1:0] input_data_real;
  logic [no_in_out*data_width-1:0] input_data_imag;
  logic                            out_valid;
  logic                            out_ready;
  logic [data_width-1:0]           out_real;
  logic [data_width-1:0]           out_imag;
  logic [idx_w-1:0]                out_index;
  logic                            out_last;

  modport master (
    output in_valid, input_data_real, input_data_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_index, out_last
  );

  modport slave (
    input  in_valid, input_data_real, input_data_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_index, out_last
  );
endinterface

// File: rtl/demapper_serializer.sv
// Captures a parallel frame of complex samples and streams it out one sample
// per handshake, reordering each group of 8 by a 3-bit bit-reversal.
module demapper_serializer #(
  parameter int data_width = 8,
  parameter int no_in_out  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demapper_serializer_if.slave  bus,
  output logic                  state_dbg
);
  localparam int idx_w   = $clog2(no_in_out);
  localparam int frame_w = no_in_out * data_width;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t             state;
  logic [frame_w-1:0] buf_real;
  logic [frame_w-1:0] buf_imag;
  logic               frame_hs;
  logic               sample_hs;
  logic [idx_w-1:0]   k_next;
  logic [idx_w-1:0]   src_next;

  // Upper index bits pass through; the low three bits are reversed.
  function automatic logic [idx_w-1:0] perm(input logic [idx_w-1:0] k);
    logic [idx_w-1:0] p;
    p      = k;
    p[2:0] = {k[0], k[1], k[2]};
    return p;
  endfunction

  assign sample_hs     = bus.out_valid & bus.out_ready;
  assign bus.in_ready  = (state == IDLE) | (sample_hs & bus.out_last);
  assign frame_hs      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state == STREAM);
  assign state_dbg     = state;
  assign k_next        = bus.out_index + idx_w'(1);
  assign src_next      = perm(k_next);

  // out_index doubles as the sample counter; data outputs are preloaded with
  // the next sample so they only move on a sample handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      buf_real      <= '0;
      buf_imag      <= '0;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
      bus.out_real  <= '0;
      bus.out_imag  <= '0;
    end else if (frame_hs) begin
      state         <= STREAM;
      buf_real      <= bus.input_data_real;
      buf_imag      <= bus.input_data_imag;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
      bus.out_real  <= bus.input_data_real[data_width-1:0];
      bus.out_imag  <= bus.input_data_imag[data_width-1:0];
    end else if (sample_hs) begin
      if (bus.out_last) begin
        state         <= IDLE;
        bus.out_index <= '0;
        bus.out_last  <= 1'b0;
      end else begin
        bus.out_index <= k_next;
        bus.out_last  <= (k_next == idx_w'(no_in_out - 1));
        bus.out_real  <= buf_real[int'(src_next) * data_width +: data_width];
        bus.out_imag  <= buf_imag[int'(src_next) * data_width +: data_width];
      end
    end
  end
endmodule
